// File: rtl/servax_rst_pkg.sv
// rtl/servax_rst_pkg.sv - shared types and constants for the reset sequencer
package servax_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD       = 2'd0,
    ST_STRETCH    = 2'd1,
    ST_REL_PERIPH = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR = 2'b01;
  localparam cause_t CAUSE_BTN = 2'b10;

endpackage

// File: rtl/servax_rst_seq_if.sv
// rtl/servax_rst_seq_if.sv - button input and reset/status outputs of the sequencer
interface servax_rst_seq_if;
  import servax_rst_pkg::*;

  logic   btn;
  logic   rst_periph;
  logic   rst_cpu;
  logic   ready;
  cause_t cause;

  modport master (input btn, output rst_periph, rst_cpu, ready, cause);
  modport slave  (output btn, input rst_periph, rst_cpu, ready, cause);

endinterface

// File: rtl/servax_debounce.sv
// rtl/servax_debounce.sv - two-flop synchroniser and counting debouncer with rise pulse
module servax_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample equal to the current level restarts the run count.
  always_comb begin
    db_d   = db_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_d;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_q    = db_q;
  assign o_rise = rise_q;

endmodule

// File: rtl/servax_rst_seq.sv
// rtl/servax_rst_seq.sv - staged peripheral/CPU reset release with debounced button restart
module servax_rst_seq
  import servax_rst_pkg::*;
#(
  parameter int STRETCH_CYCLES  = 1024,
  parameter int GAP_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic       o_rst_periph,
  output logic       o_rst_cpu,
  output logic       o_ready,
  output logic [1:0] o_cause
);

  localparam int            SW     = $clog2(STRETCH_CYCLES) + 1;
  localparam int            GW     = $clog2(GAP_CYCLES) + 1;
  localparam logic [SW-1:0] S_LAST = SW'(STRETCH_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  cause_t        cause_q, cause_d;
  logic          periph_q, periph_d;
  logic          cpu_q, cpu_d;
  logic          ready_q, ready_d;
  logic          btn_db, btn_rise;

  servax_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_btn),
    .o_q    (btn_db),
    .o_rise (btn_rise)
  );

  // A button press outranks any counter expiring on the same edge.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    cause_d = cause_q;
    if (btn_rise) begin
      state_d = ST_HOLD;
      cause_d = CAUSE_BTN;
      scnt_d  = '0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!btn_db) begin
            state_d = ST_STRETCH;
            scnt_d  = '0;
          end
        end
        ST_STRETCH: begin
          if (scnt_q == S_LAST) begin
            state_d = ST_REL_PERIPH;
            gcnt_d  = '0;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_REL_PERIPH: begin
          if (gcnt_q == G_LAST) begin
            state_d = ST_RUN;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end

    // Decoded from the next state so every output moves with the state entry.
    periph_d = (state_d == ST_HOLD) || (state_d == ST_STRETCH);
    cpu_d    = (state_d != ST_RUN);
    ready_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_HOLD;
      scnt_q   <= '0;
      gcnt_q   <= '0;
      cause_q  <= CAUSE_POR;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      gcnt_q   <= gcnt_d;
      cause_q  <= cause_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      ready_q  <= ready_d;
    end
  end

  assign o_rst_periph = periph_q;
  assign o_rst_cpu    = cpu_q;
  assign o_ready      = ready_q;
  assign o_cause      = cause_q;

endmodule

// File: tb/tb_servax_rst_seq.sv
// tb/tb_servax_rst_seq.sv - table, corner-case and random checks of servax_rst_seq
module tb_servax_rst_seq;
  import servax_rst_pkg::*;

  localparam int S0 = 16;
  localparam int G0 = 8;
  localparam int S1 = 1;
  localparam int G1 = 1;
  localparam int NDB = 4;

  typedef struct {
    logic       btn;
    int         n;
    logic       periph;
    logic       cpu;
    logic       ready;
    logic [1:0] cause;
  } vec_t;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_v[2];
  logic btn_v[2];
  int   n_chk = 0;
  int   n_fail = 0;

  servax_rst_seq_if rif0 ();
  servax_rst_seq_if rif1 ();

  assign rif0.btn = btn_v[0];
  assign rif1.btn = btn_v[1];

  servax_rst_seq #(.STRETCH_CYCLES(S0), .GAP_CYCLES(G0), .DEBOUNCE_CYCLES(NDB)) dut0 (
    .i_clk(clk), .i_rst(rst_v[0]), .i_btn(rif0.btn),
    .o_rst_periph(rif0.rst_periph), .o_rst_cpu(rif0.rst_cpu),
    .o_ready(rif0.ready), .o_cause(rif0.cause)
  );

  servax_rst_seq #(.STRETCH_CYCLES(S1), .GAP_CYCLES(G1), .DEBOUNCE_CYCLES(NDB)) dut1 (
    .i_clk(clk), .i_rst(rst_v[1]), .i_btn(rif1.btn),
    .o_rst_periph(rif1.rst_periph), .o_rst_cpu(rif1.rst_cpu),
    .o_ready(rif1.ready), .o_cause(rif1.cause)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Reference model: time since the last hold released, plus a sample history for the button.
  logic        m_s1[2], m_s2[2], m_db[2], m_rp[2], m_hold[2];
  int          m_t[2], m_nh[2];
  logic [1:0]  m_cause[2];
  logic [31:0] m_hist[2];

  function automatic int sp(int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic int gp(int d);
    return (d == 0) ? G0 : G1;
  endfunction

  task automatic m_reset(int d);
    m_s1[d] = 1'b0; m_s2[d] = 1'b0; m_db[d] = 1'b0; m_rp[d] = 1'b0;
    m_hold[d] = 1'b1; m_t[d] = 0; m_nh[d] = 0; m_hist[d] = '0;
    m_cause[d] = CAUSE_POR;
  endtask

  task automatic m_edge(int d);
    logic s2p, dbp;
    logic [31:0] mask;
    if (rst_v[d]) begin
      m_reset(d);
      return;
    end
    s2p = m_s2[d];
    dbp = m_db[d];
    if (m_rp[d]) begin
      m_hold[d]  = 1'b1;
      m_cause[d] = CAUSE_BTN;
    end else if (m_hold[d]) begin
      if (!dbp) begin
        m_hold[d] = 1'b0;
        m_t[d]    = 0;
      end
    end else if (m_t[d] < 1000000) begin
      m_t[d]++;
    end
    m_hist[d] = {m_hist[d][30:0], s2p};
    if (m_nh[d] < 32) m_nh[d]++;
    mask = (32'd1 << NDB) - 32'd1;
    m_rp[d] = 1'b0;
    if (m_nh[d] >= NDB && (m_hist[d] & mask) == (dbp ? 32'd0 : mask)) begin
      m_db[d] = !dbp;
      m_rp[d] = !dbp;
    end
    m_s2[d] = m_s1[d];
    m_s1[d] = btn_v[d];
  endtask

  function automatic logic [4:0] m_out(int d);
    logic p, c;
    p = m_hold[d] || (m_t[d] < sp(d));
    c = m_hold[d] || (m_t[d] < sp(d) + gp(d));
    return {p, c, !c, m_cause[d]};
  endfunction

  function automatic logic [4:0] dut_out(int d);
    if (d == 0) return {rif0.rst_periph, rif0.rst_cpu, rif0.ready, rif0.cause};
    return {rif1.rst_periph, rif1.rst_cpu, rif1.ready, rif1.cause};
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (periph,cpu,ready,cause)", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] o;
    @(posedge clk);
    m_edge(0);
    m_edge(1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = dut_out(d);
      chk($sformatf("model_dut%0d", d), o, m_out(d));
      n_chk++;
      if (o[4] && !o[3]) begin
        n_fail++;
        $display("FAIL order_dut%0d: got periph=%b cpu=%b expected cpu high while periph high", d, o[4], o[3]);
      end
    end
  endtask

  task automatic pulse_rst(int d);
    rst_v[d] = 1'b1;
    #1;
    m_reset(d);
    chk($sformatf("async_rst_dut%0d", d), dut_out(d), 5'b11001);
    #1;
    rst_v[d] = 1'b0;
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 16, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[1]  = '{1'b0,  1, 1'b0, 1'b1, 1'b0, 2'b01};
    tbl[2]  = '{1'b0,  7, 1'b0, 1'b1, 1'b0, 2'b01};
    tbl[3]  = '{1'b0,  1, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[4]  = '{1'b0, 10, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[5]  = '{1'b1,  3, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[6]  = '{1'b0, 10, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[7]  = '{1'b1,  6, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[8]  = '{1'b1,  1, 1'b1, 1'b1, 1'b0, 2'b10};
    tbl[9]  = '{1'b1, 13, 1'b1, 1'b1, 1'b0, 2'b10};
    tbl[10] = '{1'b0, 22, 1'b1, 1'b1, 1'b0, 2'b10};
    tbl[11] = '{1'b0,  1, 1'b0, 1'b1, 1'b0, 2'b10};
    tbl[12] = '{1'b0,  7, 1'b0, 1'b1, 1'b0, 2'b10};
    tbl[13] = '{1'b0,  1, 1'b0, 1'b0, 1'b1, 2'b10};

    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    btn_v[0] = 1'b0; btn_v[1] = 1'b0;
    m_reset(0); m_reset(1);
    repeat (2) tick();
    chk("reset_dut0", dut_out(0), 5'b11001);
    chk("reset_dut1", dut_out(1), 5'b11001);

    // Power-on, glitch and press sequence on the 16/8 instance.
    rst_v[0] = 1'b0;
    for (int i = 0; i < 14; i++) begin
      btn_v[0] = tbl[i].btn;
      repeat (tbl[i].n) tick();
      chk($sformatf("table_%0d", i), dut_out(0),
          {tbl[i].periph, tbl[i].cpu, tbl[i].ready, tbl[i].cause});
    end

    // Async reset mid-REL_PERIPH with the clock stopped.
    btn_v[0] = 1'b1;
    repeat (10) tick();
    btn_v[0] = 1'b0;
    repeat (26) tick();
    chk("in_rel_periph", dut_out(0), 5'b01010);
    clk_en = 1'b0;
    #20;
    rst_v[0] = 1'b1;
    #1;
    m_reset(0);
    chk("async_no_clock", dut_out(0), 5'b11001);
    #10;
    rst_v[0] = 1'b0;
    #3;
    clk_en = 1'b1;
    repeat (30) tick();

    // Button held across reset release.
    rst_v[0] = 1'b1;
    btn_v[0] = 1'b1;
    repeat (3) tick();
    rst_v[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [4:0] o;
      tick();
      o = dut_out(0);
      chk("held_btn", {2'b00, o[4:2]}, 5'b00110);
    end
    btn_v[0] = 1'b0;
    for (int i = 0; i < 22; i++) begin
      logic [4:0] o;
      tick();
      o = dut_out(0);
      chk("held_release", {2'b00, o[4:2]}, 5'b00110);
    end
    tick();
    chk("held_stretch_done", dut_out(0), 5'b01010);
    repeat (10) tick();

    // Debounced rise arriving on the STRETCH expiry edge.
    pulse_rst(0);
    repeat (10) tick();
    btn_v[0] = 1'b1;
    repeat (6) tick();
    chk("expiry_pre", dut_out(0), 5'b11001);
    tick();
    chk("expiry_hold_wins", dut_out(0), 5'b11010);
    btn_v[0] = 1'b0;
    repeat (30) tick();

    // Minimum stretch and gap on the 1/1 instance.
    rst_v[1] = 1'b0;
    tick();
    chk("min_edge1", dut_out(1), 5'b11001);
    tick();
    chk("min_edge2", dut_out(1), 5'b01001);
    tick();
    chk("min_edge3", dut_out(1), 5'b00101);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) pulse_rst(int'($urandom_range(0, 1)));
      btn_v[0] = 1'($urandom_range(0, 1));
      btn_v[1] = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
